// File: rtl/alu_arbiter_2req.sv
// Two-requester arbiter/sequencer in front of a shared 32-bit ALU (add / eq).
// Define ALU_ARB_RR_EN for round-robin arbitration; default build is fixed priority (requester 0 wins).
module alu_arbiter_2req #(
   parameter int p_nbits = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req0_val,
   output logic               req0_rdy,
   input  logic [p_nbits-1:0] req0_in0,
   input  logic [p_nbits-1:0] req0_in1,
   input  logic               req0_op,
   input  logic               req1_val,
   output logic               req1_rdy,
   input  logic [p_nbits-1:0] req1_in0,
   input  logic [p_nbits-1:0] req1_in1,
   input  logic               req1_op,
   output logic               resp0_val,
   input  logic               resp0_rdy,
   output logic [p_nbits-1:0] resp0_data,
   output logic               resp1_val,
   input  logic               resp1_rdy,
   output logic [p_nbits-1:0] resp1_data,
   output logic [p_nbits-1:0] alu_in0,
   output logic [p_nbits-1:0] alu_in1,
   output logic               alu_op,
   input  logic [p_nbits-1:0] alu_out,
   output logic               busy,
   output logic [1:0]         dbg_state
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   // Handshakes: a transfer happens on a rising edge where val && rdy; rdy never
   // depends on anything but state, pointer and the val inputs, and val never waits on rdy.
   logic [1:0]         state;
   logic [p_nbits-1:0] opa_q;
   logic [p_nbits-1:0] opb_q;
   logic               op_q;
   logic               id_q;
   logic [p_nbits-1:0] result_q;
   logic               grant0;
   logic               grant1;
   logic               req_fire;
   logic               resp_fire;

`ifdef ALU_ARB_RR_EN
   logic               ptr_q;
`endif

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state == S_IDLE) begin
`ifdef ALU_ARB_RR_EN
         if (req0_val && req1_val) begin
            grant0 = ~ptr_q;
            grant1 = ptr_q;
         end else begin
            grant0 = req0_val;
            grant1 = req1_val;
         end
`else
         grant0 = req0_val;
         grant1 = req1_val & ~req0_val;
`endif
      end
   end

   assign req0_rdy  = grant0;
   assign req1_rdy  = grant1;
   assign req_fire  = grant0 | grant1;

   assign resp0_val = (state == S_RESP) && !id_q;
   assign resp1_val = (state == S_RESP) && id_q;
   assign resp_fire = (resp0_val && resp0_rdy) || (resp1_val && resp1_rdy);

   assign resp0_data = result_q;
   assign resp1_data = result_q;
   assign alu_in0    = opa_q;
   assign alu_in1    = opb_q;
   assign alu_op     = op_q;
   assign busy       = (state != S_IDLE);
   assign dbg_state  = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         opa_q    <= '0;
         opb_q    <= '0;
         op_q     <= 1'b0;
         id_q     <= 1'b0;
         result_q <= '0;
`ifdef ALU_ARB_RR_EN
         ptr_q    <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (req_fire) begin
                  opa_q <= grant1 ? req1_in0 : req0_in0;
                  opb_q <= grant1 ? req1_in1 : req0_in1;
                  op_q  <= grant1 ? req1_op  : req0_op;
                  id_q  <= grant1;
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               result_q <= alu_out;
               state    <= S_RESP;
            end
            S_RESP: begin
               if (resp_fire) begin
                  state <= S_IDLE;
`ifdef ALU_ARB_RR_EN
                  // favour whoever was not just served
                  ptr_q <= ~id_q;
`endif
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
